hrm_sched_25b: RTL
==================

HRM_SCHED_25B -- requirements
Module: hrm_sched_25b

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of time-multiplexed oscillator channels (2..16).
REQ-002 SHALL have port i_clk  input  1  sole clock, all state on posedge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_tick  input  1  request one update sweep over all channels.
REQ-005 SHALL have port i_cfg_vld  input  1  config write request.
REQ-006 SHALL have port o_cfg_rdy  output  1  config write accepted when high with i_cfg_vld.
REQ-007 SHALL have port i_cfg_ch  input  $clog2(N_CH)  target channel of config write.
REQ-008 SHALL have port i_cfg_en  input  1  channel enable written with config.
REQ-009 SHALL have port i_cfg_alpha  input  25 x [2]  initial cos/sin pair, hrm_25b format.
REQ-010 SHALL have port i_cfg_delta  input  25 x [2]  per-tick rotation cos/sin pair, hrm_25b format.
REQ-011 SHALL have port o_busy  output  1  sweep in progress.
REQ-012 SHALL have port o_vld  output  1  o_ch/o_val hold a fresh channel result.
REQ-013 SHALL have port o_ch  output  $clog2(N_CH)  channel index of o_val.
REQ-014 SHALL have port o_val  output  25 x [2]  updated cos/sin pair.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse, sweep complete.
REQ-016 SHALL have port o_ovr  output  1  sticky: i_tick arrived while busy.

Function
REQ-017 SHALL hold per-channel registers alpha[N_CH][2], delta[N_CH][2], en[N_CH] and instantiate exactly one hrm_25b shared by all channels.
REQ-018 SHALL implement FSM IDLE/SWEEP; IDLE -> SWEEP on i_tick in IDLE; SWEEP -> IDLE after channel N_CH-1 processed.
REQ-019 SHALL, for i_tick at cycle T in IDLE, be in SWEEP cycles T+1..T+N_CH with channel counter 0..N_CH-1, one channel per cycle, ascending.
REQ-020 SHALL in SWEEP drive hrm_25b with alpha[cnt], delta[cnt]; if en[cnt], write theta back to alpha[cnt] at that clock edge; delta never modified by sweep.
REQ-021 SHALL register results: channel k processed at T+1+k gives o_vld=1, o_ch=k, o_val=theta at T+2+k; o_vld=0 for disabled channels (slot still consumed); o_val/o_ch hold last value when o_vld=0.
REQ-022 SHALL pulse o_done for one cycle at T+N_CH+1 regardless of enables; FSM is IDLE in that cycle.
REQ-023 SHALL drive o_busy = (state==SWEEP) and o_cfg_rdy = (state==IDLE), both from state register, no combinational input path.
REQ-024 SHALL on i_cfg_vld && o_cfg_rdy write alpha/delta/en of i_cfg_ch at that edge; out-of-range i_cfg_ch (N_CH not power of 2) SHALL be ignored.
REQ-025 SHALL, on i_cfg_vld and i_tick in the same IDLE cycle, perform the write and start the sweep; sweep uses the new values.
REQ-026 SHALL ignore i_tick during SWEEP (no queueing) and set o_ovr, which clears only on reset.
REQ-027 SHALL pass values unmodified between registers and hrm_25b; no rounding, saturation or width change in this block.

Reset
REQ-028 SHALL on i_rst force IDLE, counter 0, all alpha/delta/en 0, o_vld/o_done/o_ovr/o_busy 0, o_ch 0, o_val 0 in the next cycle.
REQ-029 SHALL on reset mid-sweep abort immediately: no further o_vld, no o_done; o_cfg_rdy=1 the cycle after reset deasserts; reset dominates i_tick and i_cfg_vld.

Verification
REQ-030 Reset then tick at T, N_CH=4, all disabled -> o_busy T+1..T+4, o_vld never 1, o_done only at T+5, o_cfg_rdy=1 at T+5.
REQ-031 Config ch2 en=1, delta = identity (cos=ONE, sin=0), alpha=(A,B); tick at T -> o_vld only at T+4 with o_ch=2, o_val=(A,B); repeat tick, same result.
REQ-032 All 4 enabled, random alpha/delta; 8 ticks -> each o_val equals 8-step hrm_25b reference model per channel; o_ch sequence 0,1,2,3 per sweep.
REQ-033 Config ch1 and i_tick same cycle -> ch1 result at T+3 reflects new alpha/delta; o_cfg_rdy=0 and writes blocked T+1..T+4.
REQ-034 Tick at T and T+2 -> second ignored, o_ovr=1 from T+3 until reset; exactly one o_done.
REQ-035 Reset asserted at T+2 of a sweep -> next cycle all outputs 0, alpha/delta zeroed, no o_done; subsequent tick sweeps with o_vld never 1.

Source files
------------

// File: rtl/hrm_sched_25b.sv
// rtl/hrm_sched_25b.sv - time-multiplexed oscillator channel scheduler around one shared hrm_25b rotator
//
// hrm_25b: combinational complex rotation theta = alpha * delta on cos/sin pairs.
//   Format: [0]=cos, [1]=sin, each 25-bit signed two's complement with 23 fraction
//   bits (ONE = 2**23). Full-precision products, arithmetic shift right by 23 (floor),
//   then wrap to 25 bits.
//   Ports: i_alpha, i_delta (in, 2x25), o_theta (out, 2x25).
//
// hrm_sched_25b: per-channel alpha/delta/en storage; each i_tick sweeps channels
//   0..N_CH-1 one per cycle through the single hrm_25b, writing theta back into
//   alpha for enabled channels and presenting registered results.
//   Ports: i_clk, i_rst (sync, active-high), i_tick (start sweep),
//          i_cfg_vld/o_cfg_rdy/i_cfg_ch/i_cfg_en/i_cfg_alpha/i_cfg_delta (channel config write),
//          o_busy (sweeping), o_vld/o_ch/o_val (per-channel result),
//          o_done (sweep complete pulse), o_ovr (sticky tick-while-busy).

module hrm_25b (
  input  logic [1:0][24:0] i_alpha,
  input  logic [1:0][24:0] i_delta,
  output logic [1:0][24:0] o_theta
);
  logic signed [24:0] a_c, a_s, d_c, d_s;
  logic signed [49:0] p_cc, p_ss, p_cs, p_sc;
  logic signed [50:0] re, im;

  assign a_c = i_alpha[0];
  assign a_s = i_alpha[1];
  assign d_c = i_delta[0];
  assign d_s = i_delta[1];

  assign p_cc = 50'(a_c) * 50'(d_c);
  assign p_ss = 50'(a_s) * 50'(d_s);
  assign p_cs = 50'(a_c) * 50'(d_s);
  assign p_sc = 50'(a_s) * 50'(d_c);

  assign re = 51'(p_cc) - 51'(p_ss);
  assign im = 51'(p_cs) + 51'(p_sc);

  // Drop the 23 fraction bits of the product, keep 25 bits (wraps on overflow).
  assign o_theta[0] = 25'(re >>> 23);
  assign o_theta[1] = 25'(im >>> 23);
endmodule

module hrm_sched_25b #(
  parameter int N_CH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tick,
  input  logic                    i_cfg_vld,
  output logic                    o_cfg_rdy,
  input  logic [$clog2(N_CH)-1:0] i_cfg_ch,
  input  logic                    i_cfg_en,
  input  logic [1:0][24:0]        i_cfg_alpha,
  input  logic [1:0][24:0]        i_cfg_delta,
  output logic                    o_busy,
  output logic                    o_vld,
  output logic [$clog2(N_CH)-1:0] o_ch,
  output logic [1:0][24:0]        o_val,
  output logic                    o_done,
  output logic                    o_ovr
);
  localparam int CW = $clog2(N_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
  localparam logic [CW:0]   N_CH_W  = (CW + 1)'(N_CH);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [1:0][24:0] alpha [N_CH];
  logic [1:0][24:0] delta [N_CH];
  logic [N_CH-1:0]  en;
  logic [1:0][24:0] theta;
  logic             cfg_wr;
  logic             last;

  hrm_25b u_hrm (
    .i_alpha (alpha[cnt]),
    .i_delta (delta[cnt]),
    .o_theta (theta)
  );

  assign last = (cnt == LAST_CH);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_tick) state_nxt = SWEEP;
      SWEEP:   if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy    = (state == SWEEP);
  assign o_cfg_rdy = (state == IDLE);
  // Indices beyond N_CH-1 only exist when N_CH is not a power of two; drop them.
  assign cfg_wr    = i_cfg_vld && (state == IDLE) && ({1'b0, i_cfg_ch} < N_CH_W);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == SWEEP && !last) ? cnt + 1'b1 : '0;
    end
  end

  // Config writes only happen in IDLE and write-back only in SWEEP, so they never collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_CH; i++) begin
        alpha[i] <= '0;
        delta[i] <= '0;
      end
      en <= '0;
    end else begin
      if (cfg_wr) begin
        alpha[i_cfg_ch] <= i_cfg_alpha;
        delta[i_cfg_ch] <= i_cfg_delta;
        en[i_cfg_ch]    <= i_cfg_en;
      end
      if (state == SWEEP && en[cnt]) alpha[cnt] <= theta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vld  <= 1'b0;
      o_ch   <= '0;
      o_val  <= '0;
      o_done <= 1'b0;
      o_ovr  <= 1'b0;
    end else begin
      o_vld  <= (state == SWEEP) && en[cnt];
      if (state == SWEEP && en[cnt]) begin
        o_ch  <= cnt;
        o_val <= theta;
      end
      o_done <= (state == SWEEP) && last;
      if (i_tick && state == SWEEP) o_ovr <= 1'b1;
    end
  end
endmodule
